mcp3008_responder: RTL and testbench

MCP3008_RESPONDER -- requirements
Module: mcp3008_responder

---
 rtl/mcp3008_pkg.sv | 22 ++
 rtl/spi_edge_sync.sv | 39 +++
 rtl/mcp3008_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_mcp3008_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mcp3008_pkg.sv
// Shared definitions for the MCP3008 ADC responder.
//   state_e        : responder frame state
//   NUM_CH         : number of ADC input channels
//   CFG_BITS       : SGL/DIFF plus three channel-select bits
//   DEFAULT_DATA_W : default conversion result width
package mcp3008_pkg;

   localparam int unsigned NUM_CH         = 8;
   localparam int unsigned CFG_BITS       = 4;
   localparam int unsigned DEFAULT_DATA_W = 10;

   typedef enum logic [2:0] {
      StIdle,
      StWaitStart,
      StCfg,
      StSample,
      StNullbit,
      StData,
      StTail
   } state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Single-line synchroniser with rise/fall event pulses.
//   clk_i  : system clock
//   rst_ni : synchronous active-low reset (chain loads ResetVal)
//   d_i    : asynchronous input line
//   q_o    : synchronised level
//   rise_o : one-clk pulse when q_o goes 0 -> 1
//   fall_o : one-clk pulse when q_o goes 1 -> 0
// Stages must be at least 1.
module spi_edge_sync #(
   parameter int unsigned Stages   = 2,
   parameter logic        ResetVal = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [Stages-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= {Stages{ResetVal}};
         prev_q <= ResetVal;
      end else begin
         sync_q <= (sync_q << 1) | Stages'(d_i);
         prev_q <= sync_q[Stages-1];
      end
   end

   assign q_o    = sync_q[Stages-1];
   // Edges come from comparing two flops, so each pulse is exactly one clk wide.
   assign rise_o = sync_q[Stages-1] & ~prev_q;
   assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/mcp3008_responder.sv
// MCP3008 ADC emulator: answers SPI conversion requests from a master with values
// taken from ch_data.
//   clk, rst_n        : system clock, synchronous active-low reset
//   ad_clk, cs, din   : SPI clock, chip select (active low), master data in
//   dout, dout_oe     : serial result and its tri-state enable
//   ch_data           : eight DATA_W channel values, CHn at [n*DATA_W +: DATA_W]
//   conv_valid        : one-clk pulse on the clk that drives the result LSB
//   conv_ch/sgl/code  : channel, SGL/DIFF bit and result of last completed frame
//   busy              : high from start-bit capture until back in idle
// Build option: define MCP3008_LSB_TAIL_EN to replay result bits 1..DATA_W-1
// LSB-first after the LSB; otherwise the tail drives 0.
module mcp3008_responder
   import mcp3008_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DATA_W      = DEFAULT_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ad_clk,
   input  logic                     cs,
   input  logic                     din,
   output logic                     dout,
   output logic                     dout_oe,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic                     conv_valid,
   output logic [2:0]               conv_ch,
   output logic                     conv_sgl,
   output logic [DATA_W-1:0]        conv_code,
   output logic                     busy
);

   localparam int unsigned CntMax = (DATA_W > CFG_BITS) ? DATA_W : CFG_BITS;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned SetW   = $clog2(SYNC_STAGES + 1);
   localparam logic [CntW-1:0] CntCfgDone = CntW'(CFG_BITS);
   localparam logic [CntW-1:0] CntD0      = CntW'(CFG_BITS - 1);
   localparam logic [CntW-1:0] CntLsb     = CntW'(DATA_W - 2);
   localparam logic [SetW-1:0] SettleDone = SetW'(SYNC_STAGES);

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic din_s, din_rise, din_fall;
   logic unused_edges;

   spi_edge_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sclk_sync (
      .clk_i(clk), .rst_ni(rst_n), .d_i(ad_clk),
      .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );
   spi_edge_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_cs_sync (
      .clk_i(clk), .rst_ni(rst_n), .d_i(cs),
      .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
   );
   spi_edge_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_din_sync (
      .clk_i(clk), .rst_ni(rst_n), .d_i(din),
      .q_o(din_s), .rise_o(din_rise), .fall_o(din_fall)
   );
   assign unused_edges = ^{sclk_s, cs_rise, cs_fall, din_rise, din_fall};

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [CFG_BITS-1:0] cfg_q, cfg_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic [DATA_W-1:0]   sr_q, sr_d;
   logic                armed_q, armed_d;
   logic [SetW-1:0]     settle_q, settle_d;
   logic                dout_q, dout_d, oe_q, oe_d, valid_q, valid_d;
   logic [2:0]          conv_ch_q, conv_ch_d;
   logic                conv_sgl_q, conv_sgl_d;
   logic [DATA_W-1:0]   conv_code_q, conv_code_d;

   // Result for the config word as it will stand after the current rise.
   logic [CFG_BITS-1:0] cfg_next;
   logic [2:0]          sel_pos, sel_neg;
   logic [DATA_W-1:0]   ch_arr [NUM_CH];
   logic [DATA_W:0]     diff;
   logic [DATA_W-1:0]   result;

   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) ch_arr[i] = ch_data[i*DATA_W +: DATA_W];
      cfg_next = {cfg_q[CFG_BITS-2:0], din_s};
      sel_pos  = cfg_next[2:0];
      sel_neg  = {cfg_next[2:1], ~cfg_next[0]};
      diff     = {1'b0, ch_arr[sel_pos]} - {1'b0, ch_arr[sel_neg]};
      if (cfg_next[CFG_BITS-1]) result = ch_arr[sel_pos];
      else if (diff[DATA_W])    result = '0;   // negative difference clamps to zero
      else                      result = diff[DATA_W-1:0];
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         cfg_q       <= '0;
         res_q       <= '0;
         sr_q        <= '0;
         armed_q     <= 1'b0;
         settle_q    <= '0;
         dout_q      <= 1'b0;
         oe_q        <= 1'b0;
         valid_q     <= 1'b0;
         conv_ch_q   <= '0;
         conv_sgl_q  <= 1'b0;
         conv_code_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cfg_q       <= cfg_d;
         res_q       <= res_d;
         sr_q        <= sr_d;
         armed_q     <= armed_d;
         settle_q    <= settle_d;
         dout_q      <= dout_d;
         oe_q        <= oe_d;
         valid_q     <= valid_d;
         conv_ch_q   <= conv_ch_d;
         conv_sgl_q  <= conv_sgl_d;
         conv_code_q <= conv_code_d;
      end
   end

   // Next state. cs high overrides any same-clk ad_clk edge.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cfg_d    = cfg_q;
      res_d    = res_q;
      sr_d     = sr_q;
      settle_d = (settle_q == SettleDone) ? settle_q : settle_q + 1'b1;
      // The synchroniser reset value is not a real observation of cs, so only arm
      // once a post-reset sample of cs=1 has travelled through the chain.
      armed_d  = armed_q | ((settle_q == SettleDone) & cs_s);
      if (cs_s) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: if (armed_q) state_d = StWaitStart;
            StWaitStart: begin
               if (sclk_rise && din_s) begin
                  state_d = StCfg;
                  cnt_d   = '0;
               end
            end
            StCfg: begin
               if (sclk_rise && cnt_q != CntCfgDone) begin
                  cfg_d = cfg_next;
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CntD0) res_d = result;
               end else if (sclk_fall && cnt_q == CntCfgDone) begin
                  state_d = StSample;
               end
            end
            StSample: if (sclk_fall) state_d = StNullbit;
            StNullbit: begin
               if (sclk_fall) begin
                  state_d = StData;
                  cnt_d   = '0;
                  sr_d    = res_q << 1;
               end
            end
            StData: begin
               if (sclk_fall) begin
                  if (cnt_q == CntLsb) begin
                     state_d = StTail;
                     sr_d    = res_q >> 1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                     sr_d  = sr_q << 1;
                  end
               end
            end
            StTail: if (sclk_fall) sr_d = sr_q >> 1;
            default: state_d = StIdle;
         endcase
      end
   end

   // Outputs (registered next values)
   always_comb begin
      dout_d      = dout_q;
      oe_d        = oe_q;
      valid_d     = 1'b0;
      conv_ch_d   = conv_ch_q;
      conv_sgl_d  = conv_sgl_q;
      conv_code_d = conv_code_q;
      if (cs_s) begin
         dout_d = 1'b0;
         oe_d   = 1'b0;
      end else begin
         case (state_q)
            StIdle, StWaitStart: begin
               dout_d = 1'b0;
               oe_d   = 1'b0;
            end
            StCfg: begin
               if (sclk_fall && cnt_q == CntCfgDone) begin
                  dout_d = 1'b0;
                  oe_d   = 1'b1;
               end
            end
            StSample:  if (sclk_fall) dout_d = 1'b0;
            StNullbit: if (sclk_fall) dout_d = res_q[DATA_W-1];
            StData: begin
               if (sclk_fall) begin
                  dout_d = sr_q[DATA_W-1];
                  if (cnt_q == CntLsb) begin
                     valid_d     = 1'b1;
                     conv_ch_d   = cfg_q[2:0];
                     conv_sgl_d  = cfg_q[CFG_BITS-1];
                     conv_code_d = res_q;
                  end
               end
            end
            StTail: begin
               if (sclk_fall) begin
`ifdef MCP3008_LSB_TAIL_EN
                  dout_d = sr_q[0];
`else
                  dout_d = 1'b0;
`endif
               end
            end
            default: begin
               dout_d = 1'b0;
               oe_d   = 1'b0;
            end
         endcase
      end
   end

   assign dout       = dout_q;
   assign dout_oe    = oe_q;
   assign conv_valid = valid_q;
   assign conv_ch    = conv_ch_q;
   assign conv_sgl   = conv_sgl_q;
   assign conv_code  = conv_code_q;
   assign busy       = (state_q != StIdle) && (state_q != StWaitStart);

endmodule

// File: tb/tb_mcp3008_responder.sv
// Bench for mcp3008_responder: an SPI master task issues directed frames and queues
// the bits and conversion records it expects; two monitors pop and compare them.
module tb_mcp3008_responder;

   localparam int SYNC = 2;
   localparam int DW   = 10;
   localparam int HF   = 8;   // fast SPI half-period in clk cycles

   typedef struct packed {
      logic [2:0]    ch;
      logic          sgl;
      logic [DW-1:0] code;
   } conv_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            ad_clk = 1'b0;
   logic            cs = 1'b1;
   logic            din = 1'b0;
   logic            dout, dout_oe, conv_valid, conv_sgl, busy;
   logic [8*DW-1:0] ch_data = '0;
   logic [2:0]      conv_ch;
   logic [DW-1:0]   conv_code;

   int    checks = 0;
   int    errors = 0;
   logic  exp_bits [$];
   conv_t exp_conv [$];
   logic  mon_bit;
   conv_t mon_conv;
   logic [2:0]    last_ch = '0;
   logic          last_sgl = 1'b0;
   logic [DW-1:0] last_code = '0;

   always #5 clk = ~clk;

   mcp3008_responder #(.SYNC_STAGES(SYNC), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .ad_clk(ad_clk), .cs(cs), .din(din),
      .dout(dout), .dout_oe(dout_oe), .ch_data(ch_data),
      .conv_valid(conv_valid), .conv_ch(conv_ch), .conv_sgl(conv_sgl),
      .conv_code(conv_code), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Master samples dout on each ad_clk rise while the responder drives it.
   always @(posedge ad_clk) begin
      if (dout_oe === 1'b1) begin
         if (exp_bits.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dout_extra: unexpected driven bit %b at %0t", dout, $time);
         end else begin
            mon_bit = exp_bits.pop_front();
            check("dout_bit", {31'b0, dout}, {31'b0, mon_bit});
         end
      end
   end

   always @(negedge clk) begin
      if (conv_valid === 1'b1) begin
         if (exp_conv.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL conv_valid_extra: pulse with none expected, code %0h at %0t",
                     conv_code, $time);
         end else begin
            mon_conv = exp_conv.pop_front();
            check("conv_ch", {29'b0, conv_ch}, {29'b0, mon_conv.ch});
            check("conv_sgl", {31'b0, conv_sgl}, {31'b0, mon_conv.sgl});
            check("conv_code", {22'b0, conv_code}, {22'b0, mon_conv.code});
            check("lsb_with_valid", {31'b0, dout}, {31'b0, mon_conv.code[0]});
         end
      end
   end

   // One SPI frame: lead zeros, start bit, SGL + 3 channel bits, then nfalls falls
   // after the D0 rise (1 sample, 2 null, 3..12 data, then tail), then cs high.
   task automatic frame(input int lead, input logic sgl, input logic [2:0] ch,
                        input int half, input int nfalls, input logic [DW-1:0] code,
                        input logic swap, input logic [8*DW-1:0] new_data);
      logic [3:0] cfg;
      logic       b;
      cfg = {sgl, ch};
      if (nfalls >= 12) begin
         exp_conv.push_back({ch, sgl, code});
         last_ch   = ch;
         last_sgl  = sgl;
         last_code = code;
      end
      cs = 1'b0;
      wait_clk(half);
      for (int i = 0; i <= lead; i++) begin
         din = (i == lead);
         wait_clk(half);
         ad_clk = 1'b1;
         wait_clk(half);
         ad_clk = 1'b0;
      end
      for (int i = 3; i >= 0; i--) begin
         din = cfg[i];
         wait_clk(half);
         ad_clk = 1'b1;
         if (i > 0) begin
            wait_clk(half);
            ad_clk = 1'b0;
         end
      end
      if (swap) begin
         wait_clk(SYNC + 1);
         ch_data = new_data;
         wait_clk(half - SYNC - 1);
      end else begin
         wait_clk(half);
      end
      check("busy_in_frame", {31'b0, busy}, 32'd1);
      for (int f = 1; f <= nfalls; f++) begin
         if (f <= 2) b = 1'b0;
         else if (f <= 12) b = code[12-f];
         else begin
`ifdef MCP3008_LSB_TAIL_EN
            if (f <= 21) b = code[f-12];
            else b = 1'b0;
`else
            b = 1'b0;
`endif
         end
         exp_bits.push_back(b);
         ad_clk = 1'b0;
         wait_clk(half);
         ad_clk = 1'b1;
         wait_clk(half);
      end
      ad_clk = 1'b0;
      din    = 1'b0;
      wait_clk(half);
      cs = 1'b1;
      wait_clk(SYNC + 2);
      check("oe_after_cs", {31'b0, dout_oe}, 32'd0);
      check("dout_after_cs", {31'b0, dout}, 32'd0);
      wait_clk(4);
      check("busy_idle", {31'b0, busy}, 32'd0);
      check("hold_ch", {29'b0, conv_ch}, {29'b0, last_ch});
      check("hold_sgl", {31'b0, conv_sgl}, {31'b0, last_sgl});
      check("hold_code", {22'b0, conv_code}, {22'b0, last_code});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [8*DW-1:0] tmp;
      wait_clk(3);
      check("rst_dout", {31'b0, dout}, 32'd0);
      check("rst_oe", {31'b0, dout_oe}, 32'd0);
      check("rst_valid", {31'b0, conv_valid}, 32'd0);
      check("rst_ch", {29'b0, conv_ch}, 32'd0);
      check("rst_sgl", {31'b0, conv_sgl}, 32'd0);
      check("rst_code", {22'b0, conv_code}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      rst_n = 1'b1;
      wait_clk(10);

      // Single-ended CH5 at a slow SPI clock
      ch_data[5*DW +: DW] = 10'h2A5;
      frame(0, 1'b1, 3'd5, 675, 12, 10'h2A5, 1'b0, '0);

      // Differential: 600-200 = 400, reversed pair saturates at 0
      ch_data[0*DW +: DW] = 10'd600;
      ch_data[1*DW +: DW] = 10'd200;
      frame(0, 1'b0, 3'd0, HF, 12, 10'd400, 1'b0, '0);
      frame(0, 1'b0, 3'd1, HF, 12, 10'd0, 1'b0, '0);

      // Leading zeros before the start bit are ignored
      ch_data[1*DW +: DW] = 10'h15A;
      frame(0, 1'b1, 3'd1, HF, 12, 10'h15A, 1'b0, '0);
      frame(3, 1'b1, 3'd1, HF, 12, 10'h15A, 1'b0, '0);

      // Abort after 4 result bits: no conv_valid, conv_* hold the CH1 frame
      ch_data[2*DW +: DW] = 10'h3C3;
      frame(0, 1'b1, 3'd2, HF, 6, 10'h3C3, 1'b0, '0);

      // ch_data change right after the D0 snapshot does not affect the frame
      ch_data[4*DW +: DW] = 10'h0F0;
      tmp = ch_data;
      tmp[4*DW +: DW] = 10'h30F;
      frame(0, 1'b1, 3'd4, HF, 12, 10'h0F0, 1'b1, tmp);
      frame(0, 1'b1, 3'd4, HF, 12, 10'h30F, 1'b0, '0);

      // Tail: 10 extra falls after the LSB
      ch_data[3*DW +: DW] = 10'h301;
      frame(0, 1'b1, 3'd3, HF, 22, 10'h301, 1'b0, '0);

      wait_clk(20);
      check("bits_drained", exp_bits.size(), 32'd0);
      check("conv_drained", exp_conv.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
